// File: rtl/mp5_phantom_map.sv
// Phantom address map for one mp5 stage. It remembers where each phantom packet was pushed
// and turns the matching real packet into an in-place insert command one cycle later.
package mp5_pkg;
    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  pipeline;
        logic [43:0] payload;
    } Packet;
endpackage

module mp5_phantom_map
    import mp5_pkg::*;
#(
    parameter int NUM_PIPELINES = 2,
    parameter int FIFO_SIZE     = 8,
    parameter int MAP_ENTRIES   = 16,
    parameter int TIMEOUT       = 1024,
    localparam int FW = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1,
    localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1,
    localparam int CW = $clog2(MAP_ENTRIES) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rec_valid,
    input  logic [15:0]   rec_id,
    input  logic [FW-1:0] rec_fifo_id,
    input  logic [AW-1:0] rec_addr,
    input  logic          lkp_valid,
    input  Packet         lkp_pkt,
    input  logic          flush,
    output logic          insert_out,
    output logic [FW-1:0] fifo_id_out,
    output logic [AW-1:0] addr_out,
    output Packet         pkt_out,
    output logic          miss_out,
    output logic          drop_out,
    output logic          expire_out,
    output logic [15:0]   expire_id,
    output logic [CW-1:0] count_out
);

    typedef struct packed {
        logic          valid;
        logic [15:0]   id;
        logic [FW-1:0] fifo_id;
        logic [AW-1:0] addr;
        logic [15:0]   age;
    } entry_t;

    localparam logic [15:0] AGE_LAST = 16'(TIMEOUT - 1);

    entry_t [MAP_ENTRIES-1:0] tbl_q, tbl_d;
    logic          insert_q, insert_d;
    logic [FW-1:0] fifo_id_q, fifo_id_d;
    logic [AW-1:0] addr_q, addr_d;
    Packet         pkt_q, pkt_d;
    logic          miss_q, miss_d;
    logic          drop_q, drop_d;
    logic          expire_q, expire_d;
    logic [15:0]   expire_id_q, expire_id_d;
    logic [CW-1:0] count_q, count_d;

    logic [MAP_ENTRIES-1:0] hit_vec, dup_vec, alloc_vec, exp_vec;
    logic hit_any, dup_any, alloc_any, rec_go;

    always_comb begin
        hit_vec     = '0;
        dup_vec     = '0;
        alloc_vec   = '0;
        exp_vec     = '0;
        hit_any     = 1'b0;
        dup_any     = 1'b0;
        alloc_any   = 1'b0;
        fifo_id_d   = '0;
        addr_d      = '0;
        expire_d    = 1'b0;
        expire_id_d = '0;
        count_d     = '0;
        tbl_d       = tbl_q;
        rec_go      = rec_valid && !flush;

        // Lookup always sees the table as it stood at the start of the cycle.
        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (lkp_valid && !hit_any && tbl_q[i].valid && tbl_q[i].id == lkp_pkt.id &&
                32'(tbl_q[i].fifo_id) == 32'(lkp_pkt.pipeline)) begin
                hit_any    = 1'b1;
                hit_vec[i] = 1'b1;
                fifo_id_d  = tbl_q[i].fifo_id;
                addr_d     = tbl_q[i].addr;
            end
        end

        // An entry being consumed by this cycle's hit cannot absorb a duplicate record.
        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (rec_go && !dup_any && tbl_q[i].valid && !hit_vec[i] &&
                tbl_q[i].id == rec_id && tbl_q[i].fifo_id == rec_fifo_id) begin
                dup_any    = 1'b1;
                dup_vec[i] = 1'b1;
            end
        end

        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (rec_go && !dup_any && !alloc_any && !tbl_q[i].valid) begin
                alloc_any    = 1'b1;
                alloc_vec[i] = 1'b1;
            end
        end

        // A refresh by a duplicate record rescues an entry on its last cycle.
        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (tbl_q[i].valid && tbl_q[i].age == AGE_LAST && !hit_vec[i] && !dup_vec[i]) begin
                exp_vec[i] = 1'b1;
                if (!expire_d) begin
                    expire_d    = 1'b1;
                    expire_id_d = tbl_q[i].id;
                end
            end
        end

        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (flush || hit_vec[i] || exp_vec[i]) begin
                tbl_d[i] = '0;
            end else if (dup_vec[i]) begin
                tbl_d[i].addr = rec_addr;
                tbl_d[i].age  = '0;
            end else if (alloc_vec[i]) begin
                tbl_d[i] = '{valid: 1'b1, id: rec_id, fifo_id: rec_fifo_id,
                             addr: rec_addr, age: 16'd0};
            end else if (tbl_q[i].valid) begin
                tbl_d[i].age = tbl_q[i].age + 16'd1;
            end
        end

        for (int i = 0; i < MAP_ENTRIES; i++) begin
            count_d = count_d + CW'(tbl_d[i].valid);
        end

        insert_d = hit_any;
        miss_d   = lkp_valid && !hit_any;
        pkt_d    = lkp_valid ? lkp_pkt : '0;
        drop_d   = rec_go && !dup_any && !alloc_any;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_q       <= '0;
            insert_q    <= 1'b0;
            fifo_id_q   <= '0;
            addr_q      <= '0;
            pkt_q       <= '0;
            miss_q      <= 1'b0;
            drop_q      <= 1'b0;
            expire_q    <= 1'b0;
            expire_id_q <= '0;
            count_q     <= '0;
        end else begin
            tbl_q       <= tbl_d;
            insert_q    <= insert_d;
            fifo_id_q   <= fifo_id_d;
            addr_q      <= addr_d;
            pkt_q       <= pkt_d;
            miss_q      <= miss_d;
            drop_q      <= drop_d;
            expire_q    <= expire_d;
            expire_id_q <= expire_id_d;
            count_q     <= count_d;
        end
    end

    assign insert_out  = insert_q;
    assign fifo_id_out = fifo_id_q;
    assign addr_out    = addr_q;
    assign pkt_out     = pkt_q;
    assign miss_out    = miss_q;
    assign drop_out    = drop_q;
    assign expire_out  = expire_q;
    assign expire_id   = expire_id_q;
    assign count_out   = count_q;

endmodule

// File: tb/tb_mp5_phantom_map.sv
// Bench for mp5_phantom_map: two instances (long and short timeout) share one random stream,
// each checked every cycle against a table-level model, plus directed literal scenarios.
module tb_mp5_phantom_map;
    import mp5_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rec_valid;
    logic [15:0] rec_id;
    logic [0:0]  rec_fifo_id;
    logic [2:0]  rec_addr;
    logic        lkp_valid;
    Packet       lkp_pkt;
    logic        flush;

    logic        o_ins[2];
    logic [0:0]  o_fid[2];
    logic [2:0]  o_addr[2];
    Packet       o_pkt[2];
    logic        o_miss[2];
    logic        o_drop[2];
    logic        o_exp[2];
    logic [15:0] o_eid[2];
    logic [4:0]  o_cnt[2];

    always #5 clk = ~clk;

    mp5_phantom_map dut (
        .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_id(rec_id),
        .rec_fifo_id(rec_fifo_id), .rec_addr(rec_addr), .lkp_valid(lkp_valid),
        .lkp_pkt(lkp_pkt), .flush(flush), .insert_out(o_ins[0]), .fifo_id_out(o_fid[0]),
        .addr_out(o_addr[0]), .pkt_out(o_pkt[0]), .miss_out(o_miss[0]), .drop_out(o_drop[0]),
        .expire_out(o_exp[0]), .expire_id(o_eid[0]), .count_out(o_cnt[0])
    );

    mp5_phantom_map #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_id(rec_id),
        .rec_fifo_id(rec_fifo_id), .rec_addr(rec_addr), .lkp_valid(lkp_valid),
        .lkp_pkt(lkp_pkt), .flush(flush), .insert_out(o_ins[1]), .fifo_id_out(o_fid[1]),
        .addr_out(o_addr[1]), .pkt_out(o_pkt[1]), .miss_out(o_miss[1]), .drop_out(o_drop[1]),
        .expire_out(o_exp[1]), .expire_id(o_eid[1]), .count_out(o_cnt[1])
    );

    // Model state per instance: a plain table of records with lifetimes.
    int          to_cyc[2] = '{1024, 4};
    bit          m_v[2][N];
    logic [15:0] m_id[2][N];
    logic [0:0]  m_f[2][N];
    logic [2:0]  m_a[2][N];
    int          m_age[2][N];

    bit          e_ins[2], e_miss[2], e_drop[2], e_exp[2];
    logic [0:0]  e_fid[2];
    logic [2:0]  e_addr[2];
    Packet       e_pkt[2];
    logic [15:0] e_eid[2];
    int          e_cnt[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step_model();
        for (int k = 0; k < 2; k++) begin
            int hit, dup, alloc;
            bit kill[N];
            hit = -1; dup = -1; alloc = -1;
            e_ins[k] = 0; e_miss[k] = 0; e_drop[k] = 0; e_exp[k] = 0;
            e_fid[k] = '0; e_addr[k] = '0; e_pkt[k] = '0; e_eid[k] = '0; e_cnt[k] = 0;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    m_v[k][i] = 0;
                    m_age[k][i] = 0;
                end
                continue;
            end
            if (lkp_valid)
                for (int i = 0; i < N; i++)
                    if (hit < 0 && m_v[k][i] && m_id[k][i] == lkp_pkt.id &&
                        int'(m_f[k][i]) == int'(lkp_pkt.pipeline)) hit = i;
            e_ins[k]  = (hit >= 0);
            e_miss[k] = lkp_valid && hit < 0;
            e_pkt[k]  = lkp_valid ? lkp_pkt : '0;
            if (hit >= 0) begin
                e_fid[k]  = m_f[k][hit];
                e_addr[k] = m_a[k][hit];
            end
            if (rec_valid && !flush) begin
                for (int i = 0; i < N; i++)
                    if (dup < 0 && i != hit && m_v[k][i] && m_id[k][i] == rec_id &&
                        m_f[k][i] == rec_fifo_id) dup = i;
                if (dup < 0)
                    for (int i = 0; i < N; i++)
                        if (alloc < 0 && !m_v[k][i]) alloc = i;
                e_drop[k] = (dup < 0 && alloc < 0);
            end
            for (int i = 0; i < N; i++) begin
                kill[i] = flush || i == hit;
                if (m_v[k][i] && m_age[k][i] == to_cyc[k] - 1 && i != hit && i != dup) begin
                    kill[i] = 1;
                    if (!e_exp[k]) begin
                        e_exp[k] = 1;
                        e_eid[k] = m_id[k][i];
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (kill[i]) begin
                    m_v[k][i] = 0;
                    m_age[k][i] = 0;
                end else if (i == dup) begin
                    m_a[k][i] = rec_addr;
                    m_age[k][i] = 0;
                end else if (i == alloc) begin
                    m_v[k][i] = 1; m_id[k][i] = rec_id; m_f[k][i] = rec_fifo_id;
                    m_a[k][i] = rec_addr; m_age[k][i] = 0;
                end else if (m_v[k][i]) begin
                    m_age[k][i]++;
                end
                if (m_v[k][i]) e_cnt[k]++;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d insert", k), 64'(o_ins[k]), 64'(e_ins[k]));
            chk($sformatf("dut%0d fifo_id", k), 64'(o_fid[k]), 64'(e_fid[k]));
            chk($sformatf("dut%0d addr", k), 64'(o_addr[k]), 64'(e_addr[k]));
            chk($sformatf("dut%0d pkt", k), 64'(o_pkt[k]), 64'(e_pkt[k]));
            chk($sformatf("dut%0d miss", k), 64'(o_miss[k]), 64'(e_miss[k]));
            chk($sformatf("dut%0d drop", k), 64'(o_drop[k]), 64'(e_drop[k]));
            chk($sformatf("dut%0d expire", k), 64'(o_exp[k]), 64'(e_exp[k]));
            chk($sformatf("dut%0d expire_id", k), 64'(o_eid[k]), 64'(e_eid[k]));
            chk($sformatf("dut%0d count", k), 64'(o_cnt[k]), 64'(e_cnt[k]));
        end
    endtask

    task automatic idle();
        rec_valid = 0; rec_id = '0; rec_fifo_id = '0; rec_addr = '0;
        lkp_valid = 0; lkp_pkt = '0; flush = 0;
    endtask

    task automatic rec(input logic [15:0] id, input logic [0:0] f, input logic [2:0] a);
        rec_valid = 1; rec_id = id; rec_fifo_id = f; rec_addr = a;
    endtask

    task automatic lkp(input logic [15:0] id, input logic [3:0] p);
        lkp_valid = 1;
        lkp_pkt.id = id;
        lkp_pkt.pipeline = p;
        lkp_pkt.payload = 44'({$urandom(), $urandom()});
    endtask

    task automatic cycle();
        step_model();
        @(negedge clk);
        check_model();
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s dut%0d insert", tag, k), 64'(o_ins[k]), 64'd0);
            chk($sformatf("%s dut%0d pkt", tag, k), 64'(o_pkt[k]), 64'd0);
            chk($sformatf("%s dut%0d addr", tag, k), 64'(o_addr[k]), 64'd0);
            chk($sformatf("%s dut%0d miss", tag, k), 64'(o_miss[k]), 64'd0);
            chk($sformatf("%s dut%0d count", tag, k), 64'(o_cnt[k]), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        Packet saved;
        rst = 0;
        idle();
        step_model();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1;

        // Record then lookup two cycles later.
        rec(16'h0005, 1'b1, 3'd3); cycle();
        chk("t1 count after rec", 64'(o_cnt[0]), 64'd1);
        idle(); cycle();
        lkp(16'h0005, 4'd1); saved = lkp_pkt; cycle();
        chk("t1 insert", 64'(o_ins[0]), 64'd1);
        chk("t1 fifo_id", 64'(o_fid[0]), 64'd1);
        chk("t1 addr", 64'(o_addr[0]), 64'd3);
        chk("t1 pkt", 64'(o_pkt[0]), 64'(saved));
        chk("t1 count after hit", 64'(o_cnt[0]), 64'd0);

        // Lookup on empty table.
        idle(); lkp(16'h0007, 4'd0); cycle();
        chk("t2 miss", 64'(o_miss[0]), 64'd1);
        chk("t2 insert", 64'(o_ins[0]), 64'd0);
        chk("t2 count", 64'(o_cnt[0]), 64'd0);

        // Fill the table, overflow, free one, refill.
        idle(); flush = 1; cycle();
        for (int i = 0; i < 16; i++) begin
            idle(); rec(16'h0100 + 16'(i), 1'b0, 3'(i)); cycle();
        end
        chk("t3 count full", 64'(o_cnt[0]), 64'd16);
        idle(); rec(16'h0110, 1'b0, 3'd7); cycle();
        chk("t3 drop", 64'(o_drop[0]), 64'd1);
        chk("t3 count after drop", 64'(o_cnt[0]), 64'd16);
        idle(); lkp(16'h0100, 4'd0); cycle();
        chk("t3 insert entry0", 64'(o_ins[0]), 64'd1);
        chk("t3 addr entry0", 64'(o_addr[0]), 64'd0);
        idle(); rec(16'h0111, 1'b0, 3'd1); cycle();
        chk("t3 drop 18th", 64'(o_drop[0]), 64'd0);
        chk("t3 count 18th", 64'(o_cnt[0]), 64'd16);

        // Same-cycle record and lookup of the same id.
        idle(); flush = 1; cycle();
        idle(); rec(16'h0009, 1'b0, 3'd1); lkp(16'h0009, 4'd0); cycle();
        chk("t4 miss", 64'(o_miss[0]), 64'd1);
        chk("t4 count", 64'(o_cnt[0]), 64'd1);
        idle(); lkp(16'h0009, 4'd0); cycle();
        chk("t4 insert", 64'(o_ins[0]), 64'd1);

        // Expiry on the short-timeout instance.
        idle(); flush = 1; cycle();
        idle(); rec(16'h0ABC, 1'b0, 3'd2); cycle();
        chk("t5 count", 64'(o_cnt[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(); cycle();
        end
        chk("t5 no early expire", 64'(o_exp[1]), 64'd0);
        idle(); cycle();
        chk("t5 expire", 64'(o_exp[1]), 64'd1);
        chk("t5 expire_id", 64'(o_eid[1]), 64'h0ABC);
        chk("t5 count after", 64'(o_cnt[1]), 64'd0);

        // Flush alongside a lookup still hits on pre-flush state.
        idle(); flush = 1; cycle();
        for (int i = 1; i <= 3; i++) begin
            idle(); rec(16'h0020 + 16'(i), 1'b1, 3'(i)); cycle();
        end
        idle(); flush = 1; lkp(16'h0021, 4'd1); cycle();
        chk("t6 insert", 64'(o_ins[0]), 64'd1);
        chk("t6 addr", 64'(o_addr[0]), 64'd1);
        chk("t6 count", 64'(o_cnt[0]), 64'd0);

        // Asynchronous reset while an insert is pending.
        idle(); rec(16'h0030, 1'b0, 3'd5); cycle();
        idle(); lkp(16'h0030, 4'd0);
        step_model();
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        chk_all_zero("async rst");
        step_model();
        @(negedge clk);
        check_model();
        idle(); cycle();
        rst = 1;
        idle(); cycle();
        chk("post rst insert", 64'(o_ins[0]), 64'd0);

        // Random traffic over a small key space to force hits, duplicates, drops and expiries.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                rec(16'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1)
                lkp(16'($urandom_range(0, 11)), 4'($urandom_range(0, 2)));
            flush = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
